// File: rtl/pa_fpu.sv
// Operation encoding shared by the fpu and the requesters that drive it.
package pa_fpu;

  typedef enum logic [2:0] {
    op_add  = 3'd0,
    op_sub  = 3'd1,
    op_mul  = 3'd2,
    op_div  = 3'd3,
    op_sqrt = 3'd4,
    op_i2f  = 3'd5,
    op_f2i  = 3'd6
  } e_fpu_op;

endpackage

// File: rtl/fpu_arbiter.sv
// Round-robin arbiter that shares one fpu between NUM_REQ requesters and
// sequences the fpu start/cmd_end/busy handshake, with a hung-op timeout.
//
// state | meaning
// IDLE  | waiting for fpu idle and a request; arbitrates round-robin
// ISSUE | fpu_start held high, waiting for a cmd_end rising edge or timeout
// DRAIN | start dropped, waiting for fpu_busy low to return the result
module fpu_arbiter #(
  parameter int NUM_REQ        = 2,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                               clk,
  input  logic                               arst_n,
  input  logic [NUM_REQ-1:0]                 req,
  input  logic [NUM_REQ-1:0][31:0]           req_a,
  input  logic [NUM_REQ-1:0][31:0]           req_b,
  input  pa_fpu::e_fpu_op [NUM_REQ-1:0]      req_op,
  output logic [NUM_REQ-1:0]                 grant,
  output logic [NUM_REQ-1:0]                 done,
  output logic [31:0]                        resp_result,
  output logic                               resp_err,
  output logic                               arb_busy,
  output logic                               fpu_start,
  output logic [31:0]                        fpu_a,
  output logic [31:0]                        fpu_b,
  output pa_fpu::e_fpu_op                    fpu_op,
  input  logic [31:0]                        fpu_result,
  input  logic                               fpu_cmd_end,
  input  logic                               fpu_busy
);

  localparam int CW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam bit TO_EN = (TIMEOUT_CYCLES > 0);
  localparam logic [CW-1:0] CNT_LAST = TO_EN ? CW'(TIMEOUT_CYCLES - 1) : '0;

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;

  state_t        state;
  logic [PW-1:0] rr_ptr;
  logic [PW-1:0] owner;
  logic [CW-1:0] cnt;
  logic          cmd_end_q;
  logic          end_rise;
  logic          win_found;
  logic [PW-1:0] win_idx;
  logic [PW-1:0] win_next;

  assign end_rise = fpu_cmd_end & ~cmd_end_q;

  // First set request at or above rr_ptr, wrapping modulo NUM_REQ.
  always_comb begin
    int idx;
    int nxt;
    idx       = 0;
    nxt       = 0;
    win_found = 1'b0;
    win_idx   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      idx = (int'(rr_ptr) + i) % NUM_REQ;
      if (!win_found && req[idx]) begin
        win_found = 1'b1;
        win_idx   = PW'(idx);
      end
    end
    nxt      = (int'(win_idx) + 1) % NUM_REQ;
    win_next = PW'(nxt);
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state       <= IDLE;
      rr_ptr      <= '0;
      owner       <= '0;
      cnt         <= '0;
      cmd_end_q   <= 1'b0;
      grant       <= '0;
      done        <= '0;
      resp_result <= '0;
      resp_err    <= 1'b0;
      arb_busy    <= 1'b0;
      fpu_start   <= 1'b0;
      fpu_a       <= '0;
      fpu_b       <= '0;
      fpu_op      <= pa_fpu::op_add;
    end else begin
      cmd_end_q <= fpu_cmd_end;
      grant     <= '0;
      done      <= '0;
      case (state)
        IDLE: begin
          if (!fpu_busy && win_found) begin
            grant     <= NUM_REQ'(1) << win_idx;
            fpu_a     <= req_a[win_idx];
            fpu_b     <= req_b[win_idx];
            fpu_op    <= req_op[win_idx];
            owner     <= win_idx;
            rr_ptr    <= win_next;
            fpu_start <= 1'b1;
            cnt       <= '0;
            resp_err  <= 1'b0;
            arb_busy  <= 1'b1;
            state     <= ISSUE;
          end
        end
        ISSUE: begin
          cnt <= cnt + 1'b1;
          // A completion edge in the timeout cycle still counts as success.
          if (end_rise) begin
            fpu_start <= 1'b0;
            state     <= DRAIN;
          end else if (TO_EN && cnt == CNT_LAST) begin
            fpu_start <= 1'b0;
            resp_err  <= 1'b1;
            state     <= DRAIN;
          end
        end
        DRAIN: begin
          if (!fpu_busy) begin
            done        <= NUM_REQ'(1) << owner;
            resp_result <= resp_err ? '0 : fpu_result;
            arb_busy    <= 1'b0;
            state       <= IDLE;
          end
        end
        default: begin
          fpu_start <= 1'b0;
          arb_busy  <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fpu_arbiter.sv
// Directed bench for fpu_arbiter with a small mock fpu (latency, hang,
// long cmd_end and forced-busy modes).
module tb_fpu_arbiter;

  logic                          clk = 1'b0;
  logic                          arst_n = 1'b0;
  logic [1:0]                    req;
  logic [1:0][31:0]              req_a;
  logic [1:0][31:0]              req_b;
  pa_fpu::e_fpu_op [1:0]         req_op;
  logic [1:0]                    grant;
  logic [1:0]                    done;
  logic [31:0]                   resp_result;
  logic                          resp_err;
  logic                          arb_busy;
  logic                          fpu_start;
  logic [31:0]                   fpu_a;
  logic [31:0]                   fpu_b;
  pa_fpu::e_fpu_op               fpu_op;
  logic [31:0]                   fpu_result;
  logic                          fpu_cmd_end;
  logic                          fpu_busy;

  always #5 clk = ~clk;

  fpu_arbiter #(.NUM_REQ(2), .TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .arst_n(arst_n), .req(req), .req_a(req_a), .req_b(req_b),
    .req_op(req_op), .grant(grant), .done(done), .resp_result(resp_result),
    .resp_err(resp_err), .arb_busy(arb_busy), .fpu_start(fpu_start),
    .fpu_a(fpu_a), .fpu_b(fpu_b), .fpu_op(fpu_op), .fpu_result(fpu_result),
    .fpu_cmd_end(fpu_cmd_end), .fpu_busy(fpu_busy)
  );

  // mock fpu
  logic [31:0] mock_result;
  int          mock_lat;
  int          mock_hold;
  logic        mock_hang;
  logic        force_busy;
  logic        m_active, m_end_ph, m_busy, m_cmd_end;
  int          m_cnt, m_hold;

  assign fpu_result  = mock_result;
  assign fpu_cmd_end = m_cmd_end;
  assign fpu_busy    = m_busy | force_busy;

  always @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      m_active <= 1'b0; m_end_ph <= 1'b0; m_busy <= 1'b0; m_cmd_end <= 1'b0;
      m_cnt <= 0; m_hold <= 0;
    end else if (!m_active) begin
      if (fpu_start) begin
        m_active <= 1'b1; m_busy <= 1'b1; m_cnt <= mock_lat;
      end
    end else if (m_end_ph) begin
      if (m_hold <= 1) begin
        m_cmd_end <= 1'b0; m_busy <= 1'b0; m_active <= 1'b0; m_end_ph <= 1'b0;
      end else begin
        m_hold <= m_hold - 1;
      end
    end else if (!fpu_start) begin
      m_busy <= 1'b0; m_active <= 1'b0;
    end else if (!mock_hang) begin
      if (m_cnt <= 1) begin
        m_cmd_end <= 1'b1; m_end_ph <= 1'b1; m_hold <= mock_hold;
      end else begin
        m_cnt <= m_cnt - 1;
      end
    end
  end

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  task automatic do_txn(input int r, input logic [31:0] a, input logic [31:0] b,
                        input pa_fpu::e_fpu_op op, input logic [31:0] res);
    int lat;
    mock_result = res;
    req_a[r] = a; req_b[r] = b; req_op[r] = op; req[r] = 1'b1;
    lat = 0;
    do begin @(negedge clk); lat++; end while (grant == 0 && lat < 50);
    chk("txn_grant", 32'(grant), 32'(1 << r));
    chk("txn_grant_lat", lat, 1);
    chk("txn_err_cleared", 32'(resp_err), 0);
    req[r] = 1'b0;
    chk("txn_fpu_a", fpu_a, a);
    chk("txn_fpu_b", fpu_b, b);
    chk("txn_fpu_op", 32'(fpu_op), 32'(op));
    chk("txn_start", 32'(fpu_start), 1);
    chk("txn_busy", 32'(arb_busy), 1);
    lat = 0;
    do begin @(negedge clk); lat++; end while (done == 0 && lat < 100);
    chk("txn_done", 32'(done), 32'(1 << r));
    chk("txn_result", resp_result, res);
    chk("txn_err", 32'(resp_err), 0);
    @(negedge clk);
    chk("txn_done_pulse", 32'(done), 0);
    chk("txn_idle", 32'(arb_busy), 0);
  endtask

  typedef struct {
    int              r;
    logic [31:0]     a;
    logic [31:0]     b;
    pa_fpu::e_fpu_op op;
    logic [31:0]     res;
  } vec_t;

  vec_t vecs[4];

  initial begin
    int lat, k, ngr, ndone, nbad;
    logic [1:0] last_g;
    logic [31:0] a_orig;

    vecs[0] = '{0, 32'h40000000, 32'h41200000, pa_fpu::op_add, 32'h41400000}; // 2+10=12
    vecs[1] = '{1, 32'h40800000, 32'h3f800000, pa_fpu::op_sub, 32'h40400000}; // 4-1=3
    vecs[2] = '{0, 32'h3fc00000, 32'h40000000, pa_fpu::op_mul, 32'h40400000}; // 1.5*2=3
    vecs[3] = '{1, 32'h40c00000, 32'h40000000, pa_fpu::op_div, 32'h40400000}; // 6/2=3

    req = '0; req_a = '0; req_b = '0;
    req_op[0] = pa_fpu::op_add; req_op[1] = pa_fpu::op_add;
    mock_result = '0; mock_lat = 3; mock_hold = 1; mock_hang = 1'b0; force_busy = 1'b0;

    // reset state
    repeat (2) @(negedge clk);
    chk("rst_grant", 32'(grant), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_start", 32'(fpu_start), 0);
    chk("rst_busy", 32'(arb_busy), 0);
    chk("rst_fpu_a", fpu_a, 0);
    chk("rst_fpu_op", 32'(fpu_op), 32'(pa_fpu::op_add));
    chk("rst_result", resp_result, 0);
    arst_n = 1'b1;
    @(negedge clk);

    // fairness: both requesters held continuously
    mock_result = 32'h40800000;
    req_a[0] = 32'h40800000; req_b[0] = '0;
    req_a[1] = 32'h40800000; req_b[1] = '0;
    req = 2'b11;
    ngr = 0; ndone = 0; last_g = '0;
    for (int c = 0; c < 200 && ndone < 4; c++) begin
      @(negedge clk);
      if (grant != 0) begin
        chk("fair_grant", 32'(grant), (ngr % 2 == 0) ? 32'd1 : 32'd2);
        chk("fair_grant_done_excl", 32'(done), 0);
        last_g = grant;
        ngr++;
      end
      if (done != 0) begin
        chk("fair_done_owner", 32'(done), 32'(last_g));
        chk("fair_result", resp_result, 32'h40800000);
        ndone++;
      end
    end
    req = 2'b00;
    chk("fair_done_count", ndone, 4);
    chk("fair_grant_count", ngr, 4);
    @(negedge clk);

    // table-driven single transactions
    for (int i = 0; i < 4; i++)
      do_txn(vecs[i].r, vecs[i].a, vecs[i].b, vecs[i].op, vecs[i].res);

    // timeout on a hung fpu
    mock_hang = 1'b1; mock_result = 32'hdeadbeef;
    req_a[0] = 32'h40000000; req_b[0] = 32'h40000000; req[0] = 1'b1;
    lat = 0;
    do begin @(negedge clk); lat++; end while (grant == 0 && lat < 50);
    chk("to_grant", 32'(grant), 1);
    req[0] = 1'b0;
    k = 0;
    do begin @(negedge clk); k++; end while (fpu_start && k < 40);
    chk("to_start_cycles", k, 16);
    lat = 0;
    while (done == 0 && lat < 50) begin @(negedge clk); lat++; end
    chk("to_done", 32'(done), 1);
    chk("to_err", 32'(resp_err), 1);
    chk("to_result", resp_result, 0);
    @(negedge clk);
    chk("to_err_hold", 32'(resp_err), 1);
    mock_hang = 1'b0;
    do_txn(0, 32'h40000000, 32'h41200000, pa_fpu::op_add, 32'h41400000);

    // fpu busy blocks arbitration
    force_busy = 1'b1;
    mock_result = 32'h40000000;
    req_a[1] = 32'h3f800000; req_b[1] = 32'h3f800000; req_op[1] = pa_fpu::op_add;
    req[1] = 1'b1;
    ngr = 0;
    repeat (6) begin @(negedge clk); if (grant != 0) ngr++; end
    chk("busy_no_grant", ngr, 0);
    force_busy = 1'b0;
    @(negedge clk);
    chk("busy_grant_after", 32'(grant), 2);
    req[1] = 1'b0;
    lat = 0;
    while (done == 0 && lat < 50) begin @(negedge clk); lat++; end
    chk("busy_done", 32'(done), 2);
    chk("busy_result", resp_result, 32'h40000000);
    @(negedge clk);

    // async reset mid-ISSUE
    mock_lat = 10;
    req_a[0] = 32'h40400000; req_b[0] = 32'h40400000; req[0] = 1'b1;
    @(negedge clk);
    chk("rst_mid_grant", 32'(grant), 1);
    req[0] = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_mid_start_before", 32'(fpu_start), 1);
    chk("rst_mid_busy_before", 32'(arb_busy), 1);
    #2 arst_n = 1'b0;
    #1;
    chk("rst_mid_start", 32'(fpu_start), 0);
    chk("rst_mid_busy", 32'(arb_busy), 0);
    chk("rst_mid_grant0", 32'(grant), 0);
    chk("rst_mid_done0", 32'(done), 0);
    repeat (2) @(negedge clk);
    arst_n = 1'b1;
    mock_lat = 3;
    nbad = 0;
    repeat (20) begin @(negedge clk); if (done != 0) nbad++; end
    chk("rst_mid_no_done", nbad, 0);
    do_txn(0, 32'h3f800000, 32'h00000000, pa_fpu::op_add, 32'h3f800000);

    // cmd_end held high for 5 cycles; operands changed after grant
    mock_hold = 5; mock_result = 32'h40800000;
    a_orig = 32'h40400000;
    req_a[0] = a_orig; req_b[0] = 32'h3f800000; req_op[0] = pa_fpu::op_add;
    req[0] = 1'b1;
    @(negedge clk);
    chk("hold_grant", 32'(grant), 1);
    req[0] = 1'b0;
    req_a[0] = 32'hffffffff;
    ndone = 0; nbad = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (done != 0) begin
        ndone++;
        chk("hold_result", resp_result, 32'h40800000);
      end
      if (fpu_a !== a_orig) nbad++;
    end
    chk("hold_one_done", ndone, 1);
    chk("hold_fpu_a_stable", nbad, 0);
    chk("hold_fpu_a", fpu_a, a_orig);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
